// File: rtl/spart_rx.sv
// Receive half of the mini SPART: recovers 8N1 frames from rxd using the 16x baud
// enable and presents each byte with data-available, overrun and framing-error flags.
module spart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_en,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       overrun,
    output logic       framing_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;

    state_e                 state_q;
    logic [3:0]             tick_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic [7:0]             rx_data_q;
    logic                   rda_q;
    logic                   overrun_q;
    logic                   framing_err_q;

    assign rxs = sync_q[SYNC_STAGES-1];

    // NOTE: the synchronizer resets to 1 (idle line) so that releasing reset
    // never looks like a falling edge and starts a phantom frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_prev_q <= rxs;
        end
    end

    // NOTE: all state below is updated with non-blocking assignments only, so the
    // rd clear and a same-cycle flag set resolve by statement order (set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_cnt_q    <= 4'd0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rda_q         <= 1'b0;
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            if (rd) begin
                rda_q         <= 1'b0;
                overrun_q     <= 1'b0;
                framing_err_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs) begin
                        tick_cnt_q <= 4'd0;
                        state_q    <= START;
                    end
                end

                START: begin
                    if (baud_en) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        // Mid start bit: a high line here means the edge was a glitch.
                        if (tick_cnt_q == 4'd7) begin
                            if (!rxs) begin
                                tick_cnt_q <= 4'd0;
                                bit_cnt_q  <= 3'd0;
                                state_q    <= DATA;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end

                DATA: begin
                    if (baud_en) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            shift_q   <= {rxs, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end
                    end
                end

                STOP: begin
                    if (baud_en) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            state_q <= IDLE;
                            if (rxs) begin
                                rx_data_q     <= shift_q;
                                rda_q         <= 1'b1;
                                framing_err_q <= 1'b0;
                                if (rda_q && !rd) begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                framing_err_q <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign overrun     = overrun_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_spart_rx.sv
// Randomized and directed frames for spart_rx, checked against a frame-level
// model of the receive flags kept in the bench.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en;
    logic       rxd;
    logic       rd;
    logic [7:0] rx_data;
    logic       rda;
    logic       overrun;
    logic       framing_err;

    int n_vec  = 0;
    int n_miss = 0;
    int bcnt;

    logic [7:0] m_data;
    logic       m_rda;
    logic       m_ovr;
    logic       m_fe;

    always #5 clk = ~clk;

    spart_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_en     (baud_en),
        .rxd         (rxd),
        .rd          (rd),
        .rx_data     (rx_data),
        .rda         (rda),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rx_data"},     rx_data,              m_data);
        check({tag, ".rda"},         {7'b0, rda},          {7'b0, m_rda});
        check({tag, ".overrun"},     {7'b0, overrun},      {7'b0, m_ovr});
        check({tag, ".framing_err"}, {7'b0, framing_err},  {7'b0, m_fe});
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
    endtask

    // Effect of one complete frame on the visible registers.
    task automatic model_frame(input logic [7:0] b, input logic stop, input bit rd_at_stop);
        if (stop) begin
            m_ovr  = (m_rda && !rd_at_stop) ? 1'b1 : (rd_at_stop ? 1'b0 : m_ovr);
            m_data = b;
            m_rda  = 1'b1;
            m_fe   = 1'b0;
        end else begin
            m_fe = 1'b1;
            if (rd_at_stop) begin
                m_rda = 1'b0;
                m_ovr = 1'b0;
            end
        end
    endtask

    // Advance to the next falling clock edge; baud_en pulses one clk in every 16.
    task automatic step();
        @(negedge clk);
        bcnt    = (bcnt + 1) % 16;
        baud_en = (bcnt == 0);
    endtask

    task automatic idle(input int n);
        rd  = 1'b0;
        rxd = 1'b1;
        repeat (n) step();
    endtask

    task automatic pulse_rd();
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        m_rda = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    // Drives ncyc clocks of a frame (256 clocks per bit). The receiver counts baud
    // ticks from the 4th rising edge after the start edge is driven; rd_at_stop
    // raises rd exactly on the 152nd such tick, the stop-bit sample.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_at_stop,
                              input int glitch_bit, input int ncyc);
        logic [9:0] f;
        int         ticks;
        int         bi;
        f     = {stop, b, 1'b0};
        ticks = 0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            bi  = c / 256;
            rxd = f[bi];
            if (glitch_bit >= 1 && glitch_bit <= 8 && bi == glitch_bit &&
                (c % 256) >= 40 && (c % 256) < 42) begin
                rxd = ~rxd;
            end
            rd = 1'b0;
            if (c >= 3 && baud_en) begin
                ticks++;
                if (rd_at_stop && ticks == 152) rd = 1'b1;
            end
        end
        rd = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic stop,
                         input bit rd_at_stop, input int glitch_bit);
        send_frame(b, stop, rd_at_stop, glitch_bit, 2560);
        model_frame(b, stop, rd_at_stop);
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        bit         rrd;
        int         gap;

        bcnt    = $urandom_range(0, 15);
        baud_en = 1'b0;
        rxd     = 1'b1;
        rd      = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");

        idle(5);
        rst_n = 1'b1;
        idle(100);

        frame("valid_55", 8'h55, 1'b1, 1'b0, 0);
        pulse_rd();
        check_outputs("rd_after_55");

        for (int c = 0; c < 48; c++) begin
            step();
            rxd = 1'b0;
        end
        idle(600);
        check_outputs("false_start");
        frame("after_false_a5", 8'hA5, 1'b1, 1'b0, 0);
        pulse_rd();

        frame("framing_a3", 8'hA3, 1'b0, 1'b0, 0);
        idle(300);
        frame("after_fe_3c", 8'h3C, 1'b1, 1'b0, 0);
        pulse_rd();

        frame("ovr_first_12", 8'h12, 1'b1, 1'b0, 0);
        frame("ovr_second_34", 8'h34, 1'b1, 1'b0, 0);
        pulse_rd();
        check_outputs("ovr_rd");

        frame("pre_77_66", 8'h66, 1'b1, 1'b0, 0);
        frame("rd_at_stop_77", 8'h77, 1'b1, 1'b1, 0);
        pulse_rd();

        send_frame(8'hF0, 1'b1, 1'b0, 0, 4 * 256 + 100);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset_mid_frame");
        idle(10);
        rst_n = 1'b1;
        idle(300);
        frame("after_reset_c3", 8'hC3, 1'b1, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom % 5) != 0;
            rrd   = ($urandom % 3) == 0;
            frame($sformatf("rand%0d", i), rb, rstop, rrd, $urandom_range(0, 8));
            if ($urandom % 2 == 1) pulse_rd();
            gap = $urandom_range(0, 200);
            if (!rstop && gap < 20) gap = 20;
            idle(gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
